// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: the instruction classes the datapath decodes from IR[15:8].
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_HALT
    } decoded_instruction_type;

endpackage

// File: rtl/ks_datapath.sv
// K&S datapath: PC, IR, 4x16 register file, ALU and flags register, driven by an external control unit.
// Define KS_DP_R0_ZERO_EN to hardwire R0 to zero (writes dropped, reads return 0).
module ks_datapath
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned FLAG_W   = 4;

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [DATA_W-1:0] rf_view [NUM_REGS];
    logic [FLAG_W-1:0] flags;

    logic [1:0]        dest_idx;
    logic [1:0]        a_idx;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] alu_result;
    logic              alu_uov;
    logic              alu_sov;
    logic [DATA_W-1:0] wb_data;
    logic              reg_we;
    logic              unused_ir_bit;

    assign unused_ir_bit = ir[7];

    // Instruction decode from the opcode byte
    always_comb begin
        decoded_instruction = I_NOP;
        case (ir[15:8])
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // Register read view; R0 optionally reads as zero
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            rf_view[i] = regs[i];
        end
`ifdef KS_DP_R0_ZERO_EN
        rf_view[0] = '0;
`endif
    end

    // Operand and destination selection per instruction format
    always_comb begin
        dest_idx = ir[5:4];
        a_idx    = ir[3:2];
        op_b     = rf_view[ir[1:0]];
        case (decoded_instruction)
            I_LOAD: dest_idx = ir[6:5];
            I_MOVE: begin
                dest_idx = ir[3:2];
                a_idx    = ir[1:0];
                op_b     = '0;
            end
            default: ;
        endcase
    end

    assign op_a     = rf_view[a_idx];
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

    // ALU: carry/borrow from the 17-bit extension, signed overflow from operand/result signs
    always_comb begin
        alu_result = '0;
        alu_uov    = 1'b0;
        alu_sov    = 1'b0;
        case (operation)
            2'b00: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_uov    = sum_ext[DATA_W];
                alu_sov    = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b01: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_uov    = diff_ext[DATA_W];
                alu_sov    = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b10:   alu_result = op_a & op_b;
            default: alu_result = op_a | op_b;
        endcase
    end

    assign wb_data = c_sel ? data_in : alu_result;

`ifdef KS_DP_R0_ZERO_EN
    assign reg_we = write_reg_enable && (dest_idx != 2'd0);
`else
    assign reg_we = write_reg_enable;
`endif

    // State registers; each enable updates independently from pre-edge values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (pc_enable) begin
                pc <= branch ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
            end
            if (ir_enable) begin
                ir <= data_in;
            end
            if (reg_we) begin
                regs[dest_idx] <= wb_data;
            end
            if (flags_reg_enable) begin
                flags <= {(alu_result == '0), alu_result[DATA_W-1], alu_uov, alu_sov};
            end
        end
    end

    assign ram_addr          = addr_sel ? ir[ADDR_W-1:0] : pc;
    assign data_out          = rf_view[ir[6:5]];
    assign zero_op           = flags[3];
    assign neg_op            = flags[2];
    assign unsigned_overflow = flags[1];
    assign signed_overflow   = flags[0];

endmodule

// File: tb/tb_ks_datapath.sv
// Directed self-checking bench for ks_datapath; honours KS_DP_R0_ZERO_EN when the build defines it.
module tb_ks_datapath;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic                    flags_reg_enable;
    logic [1:0]              operation;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [4:0]              ram_addr;
    logic [15:0]             data_out;
    logic [15:0]             data_in;

    int checks;
    int errors;

    ks_datapath dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch             (branch),
        .pc_enable          (pc_enable),
        .ir_enable          (ir_enable),
        .write_reg_enable   (write_reg_enable),
        .addr_sel           (addr_sel),
        .c_sel              (c_sel),
        .flags_reg_enable   (flags_reg_enable),
        .operation          (operation),
        .decoded_instruction(decoded_instruction),
        .zero_op            (zero_op),
        .neg_op             (neg_op),
        .unsigned_overflow  (unsigned_overflow),
        .signed_overflow    (signed_overflow),
        .ram_addr           (ram_addr),
        .data_out           (data_out),
        .data_in            (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        c_sel            = 1'b1;
        data_in          = v;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        c_sel            = 1'b0;
    endtask

    task automatic test_reset();
        addr_sel = 1'b0;
        #1;
        checks++;
        if (decoded_instruction !== I_NOP) begin
            errors++; $display("FAIL reset_decode got %0d want %0d", decoded_instruction, I_NOP);
        end
        checks++;
        if (ram_addr !== 5'd0) begin
            errors++; $display("FAIL reset_ram_addr got %h want 00", ram_addr);
        end
        checks++;
        if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000",
                               {zero_op, neg_op, unsigned_overflow, signed_overflow});
        end
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_data_out got %h want 0000", data_out);
        end
    endtask

    task automatic test_fetch();
        data_in   = 16'hA11B;
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        branch    = 1'b0;
        tick();
        ir_enable = 1'b0;
        pc_enable = 1'b0;
        checks++;
        if (decoded_instruction !== I_ADD) begin
            errors++; $display("FAIL fetch_decode got %0d want %0d", decoded_instruction, I_ADD);
        end
        addr_sel = 1'b0; #1;
        checks++;
        if (ram_addr !== 5'd1) begin
            errors++; $display("FAIL fetch_pc got %h want 01", ram_addr);
        end
        addr_sel = 1'b1; #1;
        checks++;
        if (ram_addr !== 5'h1B) begin
            errors++; $display("FAIL fetch_ir_addr got %h want 1b", ram_addr);
        end
        addr_sel = 1'b0;
    endtask

    task automatic test_add_overflow();
        write_reg(2'd1, 16'h7FFF);
        write_reg(2'd2, 16'h0001);
        load_ir(16'hA136);
        operation        = 2'b00;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        #1;
        checks++;
        if (neg_op !== 1'b0) begin
            errors++; $display("FAIL add_flags_before_edge got neg=%b want 0", neg_op);
        end
        tick();
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        checks++;
        if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0101) begin
            errors++; $display("FAIL add_flags got %b want 0101",
                               {zero_op, neg_op, unsigned_overflow, signed_overflow});
        end
        load_ir(16'h8260);
        checks++;
        if (data_out !== 16'h8000) begin
            errors++; $display("FAIL add_result got %h want 8000", data_out);
        end
    endtask

    task automatic test_sub_and_or();
        logic [1:0]  ops  [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
        logic [15:0] a_v  [4] = '{16'h0005, 16'h0000, 16'hF0F0, 16'hF0F0};
        logic [15:0] b_v  [4] = '{16'h0005, 16'h0001, 16'hFF00, 16'hFF00};
        logic [15:0] r_v  [4] = '{16'h0000, 16'hFFFF, 16'hF000, 16'hFFF0};
        logic [3:0]  f_v  [4] = '{4'b1000, 4'b0110, 4'b0100, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            write_reg(2'd1, a_v[i]);
            write_reg(2'd2, b_v[i]);
            load_ir(16'hA236);
            operation        = ops[i];
            c_sel            = 1'b0;
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            tick();
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            checks++;
            if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== f_v[i]) begin
                errors++; $display("FAIL alu_flags[%0d] got %b want %b", i,
                                   {zero_op, neg_op, unsigned_overflow, signed_overflow}, f_v[i]);
            end
            load_ir(16'h8260);
            checks++;
            if (data_out !== r_v[i]) begin
                errors++; $display("FAIL alu_result[%0d] got %h want %h", i, data_out, r_v[i]);
            end
        end
        operation = 2'b00;
    endtask

    task automatic test_load_store();
        load_ir(16'h8145);
        checks++;
        if (decoded_instruction !== I_LOAD) begin
            errors++; $display("FAIL ls_decode_load got %0d want %0d", decoded_instruction, I_LOAD);
        end
        addr_sel = 1'b1; #1;
        checks++;
        if (ram_addr !== 5'd5) begin
            errors++; $display("FAIL ls_ram_addr got %h want 05", ram_addr);
        end
        c_sel            = 1'b1;
        data_in          = 16'h1234;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        c_sel            = 1'b0;
        addr_sel         = 1'b0;
        load_ir(16'h8245);
        checks++;
        if (data_out !== 16'h1234) begin
            errors++; $display("FAIL ls_store_data got %h want 1234", data_out);
        end
        // Same-cycle write and read of R2: old value until the edge
        load_ir(16'h8145);
        c_sel            = 1'b1;
        data_in          = 16'h5678;
        write_reg_enable = 1'b1;
        #1;
        checks++;
        if (data_out !== 16'h1234) begin
            errors++; $display("FAIL ls_read_before_write got %h want 1234", data_out);
        end
        tick();
        write_reg_enable = 1'b0;
        c_sel            = 1'b0;
        checks++;
        if (data_out !== 16'h5678) begin
            errors++; $display("FAIL ls_read_after_write got %h want 5678", data_out);
        end
    endtask

    task automatic test_branch_wrap();
        addr_sel = 1'b0;
        load_ir(16'h011F);
        pc_enable = 1'b1;
        branch    = 1'b1;
        tick();
        checks++;
        if (ram_addr !== 5'd31) begin
            errors++; $display("FAIL branch_to_31 got %h want 1f", ram_addr);
        end
        branch = 1'b0;
        tick();
        pc_enable = 1'b0;
        checks++;
        if (ram_addr !== 5'd0) begin
            errors++; $display("FAIL pc_wrap got %h want 00", ram_addr);
        end
        load_ir(16'h0113);
        checks++;
        if (decoded_instruction !== I_BRANCH) begin
            errors++; $display("FAIL branch_decode got %0d want %0d", decoded_instruction, I_BRANCH);
        end
        pc_enable = 1'b1;
        branch    = 1'b1;
        tick();
        checks++;
        if (ram_addr !== 5'h13) begin
            errors++; $display("FAIL branch_target got %h want 13", ram_addr);
        end
        // IR and PC on one edge: branch uses the old IR
        data_in   = 16'h0105;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
        pc_enable = 1'b0;
        branch    = 1'b0;
        checks++;
        if (ram_addr !== 5'h13) begin
            errors++; $display("FAIL simul_pc got %h want 13", ram_addr);
        end
        addr_sel = 1'b1; #1;
        checks++;
        if (ram_addr !== 5'h05) begin
            errors++; $display("FAIL simul_ir got %h want 05", ram_addr);
        end
        addr_sel = 1'b0;
    endtask

    task automatic test_decode();
        logic [7:0]              opc [10] = '{8'h82, 8'h91, 8'hA2, 8'hA3, 8'hA4,
                                              8'h02, 8'h03, 8'hFF, 8'h00, 8'h80};
        decoded_instruction_type exp [10] = '{I_STORE, I_MOVE, I_SUB, I_AND, I_OR,
                                              I_BZERO, I_BNEG, I_HALT, I_NOP, I_NOP};
        for (int i = 0; i < 10; i++) begin
            load_ir({opc[i], 8'h00});
            checks++;
            if (decoded_instruction !== exp[i]) begin
                errors++; $display("FAIL decode[%h] got %0d want %0d", opc[i], decoded_instruction, exp[i]);
            end
        end
    endtask

    task automatic test_r0_config();
        logic [15:0] exp_r0;
`ifdef KS_DP_R0_ZERO_EN
        exp_r0 = 16'h0000;
`else
        exp_r0 = 16'h00AA;
`endif
        write_reg(2'd1, 16'h00AA);
        load_ir(16'h9101);
        operation        = 2'b00;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        tick();
        write_reg_enable = 1'b0;
        load_ir(16'h8200);
        checks++;
        if (data_out !== exp_r0) begin
            errors++; $display("FAIL r0_move got %h want %h", data_out, exp_r0);
        end
    endtask

    task automatic test_reset_mid();
        write_reg(2'd1, 16'h1111);
        write_reg(2'd2, 16'h2222);
        load_ir(16'hA136);
        operation        = 2'b00;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        ir_enable        = 1'b1;
        data_in          = 16'h8260;
        rst_n            = 1'b0;
        tick();
        rst_n            = 1'b1;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        #1;
        checks++;
        if (ram_addr !== 5'd0) begin
            errors++; $display("FAIL mid_reset_pc got %h want 00", ram_addr);
        end
        checks++;
        if (decoded_instruction !== I_NOP) begin
            errors++; $display("FAIL mid_reset_ir got %0d want %0d", decoded_instruction, I_NOP);
        end
        checks++;
        if ({zero_op, neg_op, unsigned_overflow, signed_overflow} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_flags got %b want 0000",
                               {zero_op, neg_op, unsigned_overflow, signed_overflow});
        end
        load_ir(16'h8220);
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_r1 got %h want 0000", data_out);
        end
        load_ir(16'h8260);
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_r3 got %h want 0000", data_out);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        flags_reg_enable = 1'b0;
        operation        = 2'b00;
        data_in          = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_fetch();
        test_add_overflow();
        test_sub_and_or();
        test_load_store();
        test_branch_wrap();
        test_decode();
        test_r0_config();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ks_datapath.md
KS_DATAPATH -- requirements
Module: ks_datapath

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-002 SHALL have control inputs: branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, each in 1; operation in 2.
REQ-003 SHALL have status outputs: decoded_instruction out decoded_instruction_type (k_and_s_pkg); zero_op, neg_op, unsigned_overflow, signed_overflow, each out 1.
REQ-004 SHALL have memory ports: ram_addr out 5; data_out out 16 (store data); data_in in 16 (read data).

Function
REQ-005 SHALL hold PC (5b), IR (16b), register file R0-R3 (4x16b) and a flags register (4b).
REQ-006 SHALL load IR from data_in on a clk edge when ir_enable=1.
REQ-007 SHALL update PC on a clk edge when pc_enable=1: IR[4:0] if branch=1, else PC+1 mod 32 (31 wraps to 0).
REQ-008 SHALL drive ram_addr = PC when addr_sel=0, IR[4:0] when addr_sel=1, combinationally.
REQ-009 SHALL decode IR[15:8] combinationally: 0x81 I_LOAD, 0x82 I_STORE, 0x91 I_MOVE, 0xA1 I_ADD, 0xA2 I_SUB, 0xA3 I_AND, 0xA4 I_OR, 0x01 I_BRANCH, 0x02 I_BZERO, 0x03 I_BNEG, 0xFF I_HALT, any other value I_NOP.
REQ-010 SHALL use fields: LOAD dest IR[6:5]; STORE src IR[6:5]; MOVE dest IR[3:2], src IR[1:0]; ALU ops dest IR[5:4], A IR[3:2], B IR[1:0].
REQ-011 SHALL compute ALU combinationally on 16 bits: operation 00 A+B, 01 A-B, 10 A&B, 11 A|B; for I_MOVE B operand forced to 0 and A = MOVE src.
REQ-012 SHALL select write-back data: c_sel=0 ALU result, c_sel=1 data_in; write the dest register on a clk edge when write_reg_enable=1.
REQ-013 SHALL drive data_out = register addressed by IR[6:5] at all times.
REQ-014 SHALL compute ALU flags: zero = result==0; neg = result[15]; unsigned overflow = carry out (ADD) or borrow (SUB), 0 for AND/OR; signed overflow = two's-complement overflow (ADD/SUB), 0 for AND/OR.
REQ-015 SHALL latch all four flags on a clk edge when flags_reg_enable=1; status outputs SHALL be the registered flags only, one cycle after enable.
REQ-016 SHALL treat simultaneous pc_enable, ir_enable, write_reg_enable, flags_reg_enable in one edge as independent updates using pre-edge values.
REQ-017 SHALL read register operands combinationally; a write and read of the same register in one cycle returns the old value until the edge.

Reset
REQ-018 SHALL on rst_n=0 at a clk edge clear PC, IR, R0-R3, flags to 0, overriding all enables.
REQ-019 SHALL after reset output decoded_instruction=I_NOP, ram_addr=0 (addr_sel=0), all flag outputs 0, data_out=0.
REQ-020 SHALL honour reset mid-instruction; no partial update from that edge survives.

Configuration
REQ-021 SHALL when KS_DP_R0_ZERO_EN is defined hardwire R0: writes to R0 ignored, reads of R0 (operands, data_out) return 0.
REQ-022 SHALL when KS_DP_R0_ZERO_EN is undefined treat R0 as a normal writable register.

Verification
REQ-023 SHALL verify fetch: data_in=0xA1_1B?->, ir_enable=1, pc_enable=1 from reset -> IR=0xA11B, decoded I_ADD, PC=1.
REQ-024 SHALL verify add overflow: R1=0x7FFF, R2=0x0001, ADD R3=R1+R2, flags_reg_enable -> R3=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
REQ-025 SHALL verify SUB borrow/zero: R1=R2=0x0005 -> result 0, zero=1, unsigned_overflow=0; R1=0, R2=1 -> 0xFFFF, unsigned_overflow=1, neg=1.
REQ-026 SHALL verify LOAD/STORE: IR=0x8145, addr_sel=1 -> ram_addr=5; c_sel=1, data_in=0x1234, write_reg_enable -> R2=0x1234; IR=0x8245 -> data_out=0x1234.
REQ-027 SHALL verify branch/wrap: PC=31, pc_enable, branch=0 -> PC=0; IR=0x0113, branch=1 -> PC=0x13.
REQ-028 SHALL verify R0 config: MOVE R0<-R1 (R1=0x00AA) -> R0 reads 0 with KS_DP_R0_ZERO_EN, 0x00AA without; reset mid-write clears all state.
